// File: rtl/pic_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg: shared types and constants for the 8259A bus master.
//   - bus FSM / init sequencer state encodings
//   - ICW1 bit positions and OCW3 read-register select codes
//   - packed bus request payload and ICW1 marker helper
// ---------------------------------------------------------------------------
package pic_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TIMER_W = 4;

  // Bus cycle phases
  typedef enum logic [2:0] {
    BUS_IDLE   = 3'd0,
    BUS_SETUP  = 3'd1,
    BUS_STROBE = 3'd2,
    BUS_HOLD   = 3'd3,
    BUS_RECOV  = 3'd4
  } bus_state_e;

  // ICW sequencer states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ICW1 = 3'd1,
    S_ICW2 = 3'd2,
    S_ICW3 = 3'd3,
    S_ICW4 = 3'd4,
    S_DONE = 3'd5
  } seq_state_e;

  // ICW1 bit positions
  localparam int unsigned ICW1_IC4    = 0;
  localparam int unsigned ICW1_SNGL   = 1;
  localparam int unsigned ICW1_MARKER = 4;

  // OCW3 RR/RIS field encodings
  localparam logic [1:0] OCW3_RD_IRR = 2'b10;
  localparam logic [1:0] OCW3_RD_ISR = 2'b11;

  // One bus cycle request
  typedef struct packed {
    logic              rd;
    logic              a0;
    logic [DATA_W-1:0] data;
  } bus_req_t;

  // ICW1 always carries the marker bit that tells the PIC an init is starting
  function automatic logic [DATA_W-1:0] icw1_word(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r              = v;
    r[ICW1_MARKER] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/pic_bus_timer.sv
// ---------------------------------------------------------------------------
// pic_bus_timer: 4-bit loadable down-counter timing each bus FSM phase.
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   load_i   in   load value_i (asserted on the edge entering a phase)
//   value_i  in   phase length in cycles (1..15)
//   expire_o out  high during the last cycle of the loaded phase
// ---------------------------------------------------------------------------
module pic_bus_timer
  import pic_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] value_i,
  output logic               expire_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               expire_q, expire_d;

  // Count down and park at 1; expire is precomputed so it lines up with cnt_q==1
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q > TIMER_W'(1)) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
    expire_d = (cnt_d == TIMER_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/pic_bus_master.sv
// ---------------------------------------------------------------------------
// pic_bus_master: CPU-side initiator for the 8259A read/write port.
//   Command side : cmd_valid/cmd_ready/cmd_rd/cmd_a0/cmd_data, rsp_valid/rsp_data
//   Init side    : init_start, icw1..icw4, init_busy, init_done
//   PIC bus      : CS_n, WR_n, RD_n, A0, D_out, D_oe, D_in
// A single bus FSM (SETUP/STROBE/HOLD/RECOV) serves both the command port
// and the built-in ICW1..ICW4 sequencer.
// ---------------------------------------------------------------------------
module pic_bus_master
  import pic_pkg::*;
#(
  parameter int unsigned T_SETUP = 1,
  parameter int unsigned T_PULSE = 2,
  parameter int unsigned T_HOLD  = 1,
  parameter int unsigned T_RECOV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd,
  input  logic              cmd_a0,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              init_start,
  input  logic [DATA_W-1:0] icw1,
  input  logic [DATA_W-1:0] icw2,
  input  logic [DATA_W-1:0] icw3,
  input  logic [DATA_W-1:0] icw4,
  output logic              init_busy,
  output logic              init_done,
  output logic              CS_n,
  output logic              WR_n,
  output logic              RD_n,
  output logic              A0,
  output logic [DATA_W-1:0] D_out,
  output logic              D_oe,
  input  logic [DATA_W-1:0] D_in
);

  bus_state_e        bus_q, bus_d;
  seq_state_e        seq_q, seq_d;
  bus_req_t          req_q, req_d;
  bus_req_t          seq_req;
  logic [DATA_W-1:0] icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;

  logic              cs_n_q, cs_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic              a0_q, a0_d, d_oe_q, d_oe_d;
  logic [DATA_W-1:0] d_out_q, d_out_d, rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d, init_busy_q, init_busy_d, init_done_q, init_done_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_expire;

  logic bus_idle, seq_active, start_ok, cmd_fire, seq_fire, bus_done, drive;

  pic_bus_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (tmr_load),
    .value_i  (tmr_value),
    .expire_o (tmr_expire)
  );

  // Arbitration: the sequencer owns the bus while busy; init_start beats a command
  assign bus_idle   = (bus_q == BUS_IDLE);
  assign seq_active = (seq_q == S_ICW1) || (seq_q == S_ICW2) ||
                      (seq_q == S_ICW3) || (seq_q == S_ICW4);
  assign start_ok   = init_start & bus_idle & ~init_busy_q;
  assign cmd_ready  = ~reset & bus_idle & ~init_busy_q & ~init_start;
  assign cmd_fire   = cmd_valid & cmd_ready;
  assign seq_fire   = seq_active & bus_idle;
  assign bus_done   = (bus_q == BUS_RECOV) & tmr_expire;

  // Init sequencer: ICW word selection and next state
  always_comb begin
    seq_d   = seq_q;
    icw1_d  = icw1_q;
    icw2_d  = icw2_q;
    icw3_d  = icw3_q;
    icw4_d  = icw4_q;
    seq_req = '0;

    unique case (seq_q)
      S_ICW1: begin
        seq_req.a0   = 1'b0;
        seq_req.data = icw1_word(icw1_q);
      end
      S_ICW2: begin
        seq_req.a0   = 1'b1;
        seq_req.data = icw2_q;
      end
      S_ICW3: begin
        seq_req.a0   = 1'b1;
        seq_req.data = icw3_q;
      end
      S_ICW4: begin
        seq_req.a0   = 1'b1;
        seq_req.data = icw4_q;
      end
      default: ;
    endcase

    unique case (seq_q)
      S_IDLE, S_DONE: begin
        seq_d = S_IDLE;
        if (start_ok) begin
          seq_d  = S_ICW1;
          icw1_d = icw1;
          icw2_d = icw2;
          icw3_d = icw3;
          icw4_d = icw4;
        end
      end
      S_ICW1: if (bus_done) seq_d = S_ICW2;
      S_ICW2: begin
        if (bus_done) begin
          if (!icw1_q[ICW1_SNGL])     seq_d = S_ICW3;
          else if (icw1_q[ICW1_IC4])  seq_d = S_ICW4;
          else                        seq_d = S_DONE;
        end
      end
      S_ICW3: if (bus_done) seq_d = icw1_q[ICW1_IC4] ? S_ICW4 : S_DONE;
      S_ICW4: if (bus_done) seq_d = S_DONE;
      default: seq_d = S_IDLE;
    endcase
  end

  // Bus FSM: each phase loads its length into the shared timer on entry
  always_comb begin
    bus_d       = bus_q;
    req_d       = req_q;
    tmr_load    = 1'b0;
    tmr_value   = '0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    unique case (bus_q)
      BUS_IDLE: begin
        if (seq_fire) begin
          req_d     = seq_req;
          bus_d     = BUS_SETUP;
          tmr_load  = 1'b1;
          tmr_value = TIMER_W'(T_SETUP);
        end else if (cmd_fire) begin
          req_d.rd   = cmd_rd;
          req_d.a0   = cmd_a0;
          req_d.data = cmd_data;
          bus_d      = BUS_SETUP;
          tmr_load   = 1'b1;
          tmr_value  = TIMER_W'(T_SETUP);
        end
      end
      BUS_SETUP: begin
        if (tmr_expire) begin
          bus_d     = BUS_STROBE;
          tmr_load  = 1'b1;
          tmr_value = TIMER_W'(T_PULSE);
        end
      end
      BUS_STROBE: begin
        if (tmr_expire) begin
          bus_d     = BUS_HOLD;
          tmr_load  = 1'b1;
          tmr_value = TIMER_W'(T_HOLD);
          // Capture on the last strobe cycle; rsp_valid lands on the first HOLD cycle
          if (req_q.rd) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = D_in;
          end
        end
      end
      BUS_HOLD: begin
        if (tmr_expire) begin
          bus_d     = BUS_RECOV;
          tmr_load  = 1'b1;
          tmr_value = TIMER_W'(T_RECOV);
        end
      end
      BUS_RECOV: if (tmr_expire) bus_d = BUS_IDLE;
      default:   bus_d = BUS_IDLE;
    endcase
  end

  // Pin values follow the next bus state so they register in step with bus_q
  always_comb begin
    drive       = (bus_d == BUS_SETUP) || (bus_d == BUS_STROBE) || (bus_d == BUS_HOLD);
    cs_n_d      = ~drive;
    wr_n_d      = ~((bus_d == BUS_STROBE) & ~req_d.rd);
    rd_n_d      = ~((bus_d == BUS_STROBE) &  req_d.rd);
    d_oe_d      = drive & ~req_d.rd;
    a0_d        = req_d.a0;
    d_out_d     = req_d.data;
    init_busy_d = (seq_d == S_ICW1) || (seq_d == S_ICW2) ||
                  (seq_d == S_ICW3) || (seq_d == S_ICW4);
    init_done_d = (seq_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_q       <= BUS_IDLE;
      seq_q       <= S_IDLE;
      req_q       <= '0;
      icw1_q      <= '0;
      icw2_q      <= '0;
      icw3_q      <= '0;
      icw4_q      <= '0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      a0_q        <= 1'b0;
      d_out_q     <= '0;
      d_oe_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      init_busy_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      bus_q       <= bus_d;
      seq_q       <= seq_d;
      req_q       <= req_d;
      icw1_q      <= icw1_d;
      icw2_q      <= icw2_d;
      icw3_q      <= icw3_d;
      icw4_q      <= icw4_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      a0_q        <= a0_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      init_busy_q <= init_busy_d;
      init_done_q <= init_done_d;
    end
  end

  assign CS_n      = cs_n_q;
  assign WR_n      = wr_n_q;
  assign RD_n      = rd_n_q;
  assign A0        = a0_q;
  assign D_out     = d_out_q;
  assign D_oe      = d_oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign init_busy = init_busy_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_pic_bus_master.sv
// ---------------------------------------------------------------------------
// tb_pic_bus_master: directed, self-checking bench for pic_bus_master.
// Outputs are sampled and inputs driven on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_pic_bus_master;
  import pic_pkg::*;

  localparam int unsigned TS     = 1;
  localparam int unsigned TP     = 2;
  localparam int unsigned TH     = 1;
  localparam int unsigned TR     = 2;
  localparam int unsigned CS_LEN = TS + TP + TH;        // cycles CS_n low
  localparam int unsigned CYC    = 1 + TS + TP + TH + TR; // IDLE launch + phases
  localparam int unsigned NVEC   = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_rd, cmd_a0;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       init_start;
  logic [7:0] icw1, icw2, icw3, icw4;
  logic       init_busy, init_done;
  logic       CS_n, WR_n, RD_n, A0, D_oe;
  logic [7:0] D_out, D_in;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pic_bus_master #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_RECOV(TR)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_a0(cmd_a0),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .init_start(init_start), .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .init_busy(init_busy), .init_done(init_done),
    .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n), .A0(A0), .D_out(D_out), .D_oe(D_oe),
    .D_in(D_in)
  );

  typedef struct {
    logic       rd;
    logic       a0;
    logic [7:0] data;
    logic [7:0] din;
    logic       exp_a0;
    logic [7:0] exp_dout;
    int         exp_rsp_n;
    logic [7:0] exp_rsp;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One command-port bus cycle, checked cycle by cycle against the phase timing
  task automatic run_cmd(input int idx);
    vec_t       v;
    int         waitc, cs_lo, act_lo, oth_lo, first_k, both, rsp_n, rsp_k;
    int         a0_bad, dout_bad, doe_bad;
    logic       ready_end;
    logic [7:0] rsp_got;
    v = vecs[idx];
    waitc = 0; cs_lo = 0; act_lo = 0; oth_lo = 0; first_k = -1; both = 0;
    rsp_n = 0; rsp_k = -1; a0_bad = 0; dout_bad = 0; doe_bad = 0;
    ready_end = 1'b0; rsp_got = 8'h00;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rd = v.rd; cmd_a0 = v.a0; cmd_data = v.data; D_in = ~v.din;
    #1;
    while (!cmd_ready && waitc < 50) begin
      @(negedge clk); #1;
      waitc++;
    end
    chk($sformatf("v%0d_accept", idx), 32'(waitc < 50), 32'd1);
    @(negedge clk);
    for (int k = 1; k <= int'(CYC); k++) begin
      if (!CS_n) begin
        cs_lo++;
        if (A0 !== v.exp_a0) a0_bad++;
        if (!v.rd && D_out !== v.exp_dout) dout_bad++;
      end
      if (D_oe !== (!CS_n && !v.rd)) doe_bad++;
      if ((v.rd ? RD_n : WR_n) == 1'b0) begin
        act_lo++;
        if (first_k < 0) first_k = k;
      end
      if ((v.rd ? WR_n : RD_n) == 1'b0) oth_lo++;
      if (!WR_n && !RD_n) both++;
      if (rsp_valid) begin
        rsp_n++;
        rsp_k   = k;
        rsp_got = rsp_data;
      end
      if (k == int'(CYC)) ready_end = cmd_ready;
      // Scramble the request inputs after acceptance; D_in is only correct on the last strobe cycle
      cmd_valid = 1'b0; cmd_a0 = ~v.a0; cmd_data = ~v.data;
      D_in = (k == int'(TS + TP)) ? v.din : ~v.din;
      if (k < int'(CYC)) @(negedge clk);
    end
    chk($sformatf("v%0d_cs_low_cycles", idx), 32'(cs_lo), 32'(CS_LEN));
    chk($sformatf("v%0d_strobe_cycles", idx), 32'(act_lo), 32'(TP));
    chk($sformatf("v%0d_strobe_start", idx), 32'(first_k), 32'(TS + 1));
    chk($sformatf("v%0d_wrong_strobe", idx), 32'(oth_lo), 32'd0);
    chk($sformatf("v%0d_strobe_overlap", idx), 32'(both), 32'd0);
    chk($sformatf("v%0d_a0", idx), 32'(a0_bad), 32'd0);
    chk($sformatf("v%0d_dout", idx), 32'(dout_bad), 32'd0);
    chk($sformatf("v%0d_doe", idx), 32'(doe_bad), 32'd0);
    chk($sformatf("v%0d_rsp_pulses", idx), 32'(rsp_n), 32'(v.exp_rsp_n));
    if (v.rd) begin
      chk($sformatf("v%0d_rsp_cycle", idx), 32'(rsp_k), 32'(TS + TP + 1));
      chk($sformatf("v%0d_rsp_data", idx), 32'(rsp_got), 32'(v.exp_rsp));
    end
    chk($sformatf("v%0d_ready_after", idx), 32'(ready_end), 32'd1);
  endtask

  // ICW sequence: checks written words, their order, and init_done timing
  task automatic run_init(input string tag, input logic [7:0] i1, input logic [7:0] i2,
                          input logic [7:0] i3, input logic [7:0] i4, input int n_exp,
                          input logic [31:0] d_exp, input logic [3:0] a0_exp);
    int         t, nwr, done_t, done_n;
    logic       wr_prev, busy_at_done;
    logic [7:0] got_d [4];
    logic       got_a0 [4];
    logic [7:0] exp_b;
    for (int i = 0; i < 4; i++) begin got_d[i] = 8'h00; got_a0[i] = 1'b0; end
    @(negedge clk);
    init_start = 1'b1; icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4;
    @(negedge clk);
    init_start = 1'b0; icw1 = ~i1; icw2 = ~i2; icw3 = ~i3; icw4 = ~i4;
    chk({tag, "_busy_next"}, 32'(init_busy), 32'd1);
    t = 1; nwr = 0; done_t = -1; done_n = 0; wr_prev = 1'b1; busy_at_done = 1'b1;
    while (t < 200 && (done_t < 0 || t < done_t + 4)) begin
      if (!WR_n && wr_prev) begin
        if (nwr < 4) begin got_d[nwr] = D_out; got_a0[nwr] = A0; end
        nwr++;
      end
      wr_prev = WR_n;
      if (init_done) begin
        done_n++;
        if (done_t < 0) begin done_t = t; busy_at_done = init_busy; end
      end
      @(negedge clk);
      t++;
    end
    chk({tag, "_done_latency"}, 32'(done_t), 32'(1 + n_exp * int'(CYC)));
    chk({tag, "_done_pulses"}, 32'(done_n), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    chk({tag, "_write_count"}, 32'(nwr), 32'(n_exp));
    for (int i = 0; i < n_exp && i < 4; i++) begin
      exp_b = d_exp[8*i +: 8];
      chk($sformatf("%s_w%0d_a0", tag, i), 32'(got_a0[i]), 32'(a0_exp[i]));
      chk($sformatf("%s_w%0d_data", tag, i), 32'(got_d[i]), 32'(exp_b));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   t, nwr, done_t, acc_t, extra, cnt_done, cnt_cs;
    logic wr_prev, x_a0;
    logic [7:0] x_d;

    //            rd    a0    data   din    exp_a0 exp_dout rsp_n exp_rsp
    vecs[0] = '{1'b0, 1'b1, 8'hF0, 8'h00, 1'b1, 8'hF0, 0, 8'h00}; // OCW1 mask
    vecs[1] = '{1'b0, 1'b0, {3'b000, 2'b01, 1'b0, OCW3_RD_IRR}, 8'h00, 1'b0, 8'h0A, 0, 8'h00}; // OCW3 IRR
    vecs[2] = '{1'b1, 1'b0, 8'hC3, 8'h5A, 1'b0, 8'h00, 1, 8'h5A}; // IRR read
    vecs[3] = '{1'b0, 1'b0, {3'b000, 2'b01, 1'b0, OCW3_RD_ISR}, 8'h00, 1'b0, 8'h0B, 0, 8'h00}; // OCW3 ISR
    vecs[4] = '{1'b1, 1'b0, 8'h00, 8'hA5, 1'b0, 8'h00, 1, 8'hA5}; // ISR read
    vecs[5] = '{1'b1, 1'b1, 8'hFF, 8'h3C, 1'b1, 8'h00, 1, 8'h3C}; // IMR read
    vecs[6] = '{1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h20, 0, 8'h00}; // OCW2 EOI

    reset = 1'b1; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_a0 = 1'b0; cmd_data = 8'h00;
    init_start = 1'b0; icw1 = 8'h00; icw2 = 8'h00; icw3 = 8'h00; icw4 = 8'h00; D_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(CS_n), 32'd1);
    chk("rst_wr_n", 32'(WR_n), 32'd1);
    chk("rst_rd_n", 32'(RD_n), 32'd1);
    chk("rst_a0", 32'(A0), 32'd0);
    chk("rst_dout", 32'(D_out), 32'd0);
    chk("rst_doe", 32'(D_oe), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_init_busy", 32'(init_busy), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // ICW sequences: single/no ICW4, cascade+ICW4, marker forced with ICW3 skipped
    run_init("single", 8'h12, 8'h20, 8'h00, 8'h00, 2, 32'h0000_2012, 4'b0010);
    run_init("cascade", 8'h11, 8'h08, 8'h04, 8'h01, 4, 32'h0104_0811, 4'b1110);
    run_init("marker", 8'h03, 8'h40, 8'h00, 8'h03, 3, 32'h0003_4013, 4'b0110);

    for (int i = 0; i < int'(NVEC); i++) run_cmd(i);

    // Contention: init_start and cmd_valid together; init wins, command runs once afterwards
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_a0 = 1'b1; cmd_data = 8'h55;
    init_start = 1'b1; icw1 = 8'h12; icw2 = 8'h20;
    #1;
    chk("cont_ready_at_start", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    init_start = 1'b0;
    t = 1; nwr = 0; done_t = -1; acc_t = -1; wr_prev = 1'b1;
    while (t < 100 && acc_t < 0) begin
      if (!WR_n && wr_prev) nwr++;
      wr_prev = WR_n;
      if (init_done && done_t < 0) done_t = t;
      if (cmd_ready) acc_t = t;
      @(negedge clk);
      t++;
    end
    cmd_valid = 1'b0; cmd_a0 = 1'b0; cmd_data = 8'h00;
    chk("cont_done_latency", 32'(done_t), 32'(1 + 2 * int'(CYC)));
    chk("cont_accept_at_done", 32'(acc_t), 32'(done_t));
    chk("cont_icw_writes", 32'(nwr), 32'd2);
    extra = 0; x_a0 = 1'b0; x_d = 8'h00;
    for (int k = 0; k < 20; k++) begin
      if (!WR_n && wr_prev) begin extra++; x_a0 = A0; x_d = D_out; end
      wr_prev = WR_n;
      @(negedge clk);
    end
    chk("cont_cmd_writes", 32'(extra), 32'd1);
    chk("cont_cmd_a0", 32'(x_a0), 32'd1);
    chk("cont_cmd_data", 32'(x_d), 32'h55);

    // Reset during the ICW2 strobe, then a clean full sequence
    @(negedge clk);
    init_start = 1'b1; icw1 = 8'h12; icw2 = 8'h20;
    @(negedge clk);
    init_start = 1'b0;
    t = 0; nwr = 0; wr_prev = 1'b1;
    while (t < 100 && nwr < 2) begin
      if (!WR_n && wr_prev) nwr++;
      wr_prev = WR_n;
      if (nwr < 2) begin @(negedge clk); t++; end
    end
    chk("mid_reached_icw2", 32'(nwr), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_cs_n", 32'(CS_n), 32'd1);
    chk("mid_wr_n", 32'(WR_n), 32'd1);
    chk("mid_doe", 32'(D_oe), 32'd0);
    chk("mid_busy", 32'(init_busy), 32'd0);
    chk("mid_done", 32'(init_done), 32'd0);
    chk("mid_cmd_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    cnt_done = 0; cnt_cs = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (init_done) cnt_done++;
      if (!CS_n) cnt_cs++;
    end
    chk("post_rst_no_done", 32'(cnt_done), 32'd0);
    chk("post_rst_bus_quiet", 32'(cnt_cs), 32'd0);
    run_init("rerun", 8'h12, 8'h20, 8'h00, 8'h00, 2, 32'h0000_2012, 4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
